// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
//   Fetch stage of the 16-bit MIPS pipeline. Owns the program counter, presents it
//   to instruction memory and captures the returned instruction into the IF/ID
//   pipeline register. Handles stall, branch/jump redirect and a HALT opcode.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   pc             registered fetch address to instruction memory (always even)
//   instr          instruction read combinationally from memory at pc
//   stall          hold pc, IF/ID and state this cycle
//   redirect       taken branch/jump: load redirect_pc, flush IF/ID (beats stall)
//   redirect_pc    redirect target, bit 0 forced to 0
//   if_id_instr    latched instruction (0000 = NOP when not valid)
//   if_id_pc       address the latched instruction came from
//   if_id_pc_plus  if_id_pc + PC_STEP, wrapping
//   if_id_valid    IF/ID holds a real instruction
//   halted         fetch stopped by HALT_OPCODE
module instr_fetch_stage #(
  parameter int              PC_W        = 16,
  parameter int              INSTR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC    = 16'h0000,
  parameter int              PC_STEP     = 2,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus,
  output logic               if_id_valid,
  output logic               halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [PC_W-1:0]    STEP_C    = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0]    EVEN_MASK = ~{{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [INSTR_W-1:0] NOP_C     = {INSTR_W{1'b0}};

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [INSTR_W-1:0] if_id_instr_r, if_id_instr_s;
  logic [PC_W-1:0]    if_id_pc_r, if_id_pc_s;
  logic [PC_W-1:0]    if_id_pc_plus_r, if_id_pc_plus_s;
  logic               if_id_valid_r, if_id_valid_s;
  logic               halted_r;
  logic               is_halt_s;
  logic [PC_W-1:0]    pc_inc_s;

  assign is_halt_s = (instr[INSTR_W-1:INSTR_W-4] == HALT_OPCODE);
  assign pc_inc_s  = pc_r + STEP_C;

  // Next-state and next-register values; redirect beats stall beats normal fetch.
  always_comb begin
    state_s         = state_r;
    pc_s            = pc_r;
    if_id_instr_s   = if_id_instr_r;
    if_id_pc_s      = if_id_pc_r;
    if_id_pc_plus_s = if_id_pc_plus_r;
    if_id_valid_s   = if_id_valid_r;
    if (redirect) begin
      // The instruction on the bus this cycle is dropped, even a HALT.
      pc_s          = redirect_pc & EVEN_MASK;
      if_id_instr_s = NOP_C;
      if_id_valid_s = 1'b0;
      state_s       = ST_RUN;
    end else if (stall) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if_id_instr_s   = instr;
          if_id_pc_s      = pc_r;
          if_id_pc_plus_s = pc_inc_s;
          if_id_valid_s   = 1'b1;
          if (is_halt_s) begin
            // HALT itself goes down the pipe; pc parks on it.
            state_s = ST_HALTED;
          end else begin
            pc_s = pc_inc_s;
          end
        end
        ST_HALTED: begin
          if_id_instr_s = NOP_C;
          if_id_valid_s = 1'b0;
        end
        default: begin
          state_s = ST_RUN;
        end
      endcase
    end
  end

  // State and pipeline registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_RUN;
      pc_r            <= RESET_PC;
      if_id_instr_r   <= NOP_C;
      if_id_pc_r      <= {PC_W{1'b0}};
      if_id_pc_plus_r <= {PC_W{1'b0}};
      if_id_valid_r   <= 1'b0;
      halted_r        <= 1'b0;
    end else begin
      state_r         <= state_s;
      pc_r            <= pc_s;
      if_id_instr_r   <= if_id_instr_s;
      if_id_pc_r      <= if_id_pc_s;
      if_id_pc_plus_r <= if_id_pc_plus_s;
      if_id_valid_r   <= if_id_valid_s;
      halted_r        <= (state_s == ST_HALTED);
    end
  end

  assign pc            = pc_r;
  assign if_id_instr   = if_id_instr_r;
  assign if_id_pc      = if_id_pc_r;
  assign if_id_pc_plus = if_id_pc_plus_r;
  assign if_id_valid   = if_id_valid_r;
  assign halted        = halted_r;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus;
  logic        if_id_valid;
  logic        halted;

  bit [15:0] mem [0:32767];   // word-addressed instruction memory

  int passed = 0;
  int total  = 0;

  // Reference model state, plain integers and flags.
  int m_pc, m_instr, m_ipc, m_plus;
  bit m_valid, m_halted;

  typedef struct {
    bit        stall;
    bit        redirect;
    bit [15:0] rpc;
    bit [15:0] exp_pc;
    bit [15:0] exp_instr;
    bit        exp_valid;
    bit        exp_halted;
  } vec_t;

  vec_t vecs [11];

  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus(if_id_pc_plus), .if_id_valid(if_id_valid),
    .halted(halted)
  );

  assign instr = mem[pc[15:1]];

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ipc = 0; m_plus = 0; m_valid = 0; m_halted = 0;
  endtask

  // One clock edge of the fetch stage as described in words: redirect wins,
  // then stall freezes everything, otherwise fetch (or emit a bubble if halted).
  task automatic model_edge(input bit s, input bit r, input int rpc);
    int w;
    if (r) begin
      m_pc = rpc - (rpc % 2);
      m_valid = 0; m_instr = 0; m_halted = 0;
    end else if (!s) begin
      if (m_halted) begin
        m_valid = 0; m_instr = 0;
      end else begin
        w = mem[m_pc / 2];
        m_instr = w; m_ipc = m_pc; m_plus = (m_pc + 2) % 65536; m_valid = 1;
        if (w / 4096 == 15) m_halted = 1;
        else m_pc = (m_pc + 2) % 65536;
      end
    end
  endtask

  task automatic compare_model();
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_valid", if_id_valid, m_valid);
    check("halted", halted, m_halted);
    if (m_valid) begin
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_pc_plus", if_id_pc_plus, m_plus);
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare #1 after the edge.
  task automatic do_cycle(input bit s, input bit r, input bit [15:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    model_edge(s, r, int'(rpc));
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pc"}, pc, 0);
    check({tag, ".if_id_instr"}, if_id_instr, 0);
    check({tag, ".if_id_pc"}, if_id_pc, 0);
    check({tag, ".if_id_pc_plus"}, if_id_pc_plus, 0);
    check({tag, ".if_id_valid"}, if_id_valid, 0);
    check({tag, ".halted"}, halted, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem[0] = 16'h1111; mem[1] = 16'h24c2; mem[2] = 16'h2101; mem[3] = 16'h0748;
    mem[4] = 16'hF000;
    mem[16'hFFFE >> 1] = 16'h1234;
    model_reset();

    // Directed table: start-up fetch, 3-cycle stall, redirect+stall, HALT, leave HALT.
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, 16'h24c2, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h24c2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h24c2, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h24c2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0006, 16'h2101, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0009, 16'h0008, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 16'hF000, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'h0002, 16'h0002, 16'h0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_cycle(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      check($sformatf("vec%0d.pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.instr", i), if_id_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d.valid", i), if_id_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d.halted", i), halted, vecs[i].exp_halted);
      if (i == 1) begin
        check("vec1.if_id_pc", if_id_pc, 16'h0002);
        check("vec1.if_id_pc_plus", if_id_pc_plus, 16'h0004);
      end
    end

    // Fetch from the top of memory: pc wraps to 0, pc_plus wraps too.
    do_cycle(1'b0, 1'b1, 16'hFFFE);
    check("wrap.redirect_pc", pc, 16'hFFFE);
    do_cycle(1'b0, 1'b0, 16'h0000);
    check("wrap.if_id_instr", if_id_instr, 16'h1234);
    check("wrap.if_id_pc", if_id_pc, 16'hFFFE);
    check("wrap.if_id_pc_plus", if_id_pc_plus, 16'h0000);
    check("wrap.pc", pc, 16'h0000);

    // Halt, then hit reset between edges: outputs clear without a clock.
    do_cycle(1'b0, 1'b1, 16'h0008);
    do_cycle(1'b0, 1'b0, 16'h0000);
    check("pre_rst.halted", halted, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    rst = 1'b0;

    // Random program and control traffic against the model.
    for (int a = 0; a < 256; a++) begin
      bit [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h1;
      mem[a] = w;
    end
    for (int c = 0; c < 600; c++) begin
      bit s, r;
      bit [15:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = 16'($urandom_range(0, 511));
      if ($urandom_range(0, 15) == 0) t = 16'($urandom);
      do_cycle(s, r, t);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
